// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: owns the fetch PC, issues code-memory reads, buffers words in a prefetch queue.
// Latency: first inst_valid two cycles after the first issue; 1 instr/cycle sustained with inst_ready high.
// Backpressure: reads issue only while queued + in-flight words < DEPTH, so a returning word always has a slot.
module fetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     nreset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     inst_valid,
    output logic [31:0]              inst,
    output logic [31:0]              inst_pc,
    input  logic                     inst_ready,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   queue_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = DEPTH[CW:0];

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   req_pc_q;
    logic          req_epoch_q;
    logic          epoch_q, epoch_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_inst_q [DEPTH];
    logic [31:0]   mem_pc_q   [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    // Issue/push/pop decisions; a redirect suppresses all three for the cycle.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue     = nreset & ~redirect_valid & (occupancy < DEPTH_L);
        // A response whose epoch no longer matches was issued before a redirect and is stale.
        push      = inflight_q & (req_epoch_q == epoch_q) & ~redirect_valid;
        pop       = (count_q != '0) & inst_ready & ~redirect_valid;
    end

    // Next-state for fetch PC, in-flight tracking, epoch, pointers and count.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = issue;
        epoch_d    = epoch_q ^ redirect_valid;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; reset drops everything queued or in flight.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fetch_pc_q  <= RESET_PC;
            inflight_q  <= 1'b0;
            req_pc_q    <= '0;
            req_epoch_q <= 1'b0;
            epoch_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            epoch_q    <= epoch_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (issue) begin
                req_pc_q    <= fetch_pc_q;
                req_epoch_q <= epoch_q;
            end
        end
    end

    // Queue storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    // Head presentation; data is forced to zero while the queue is empty.
    always_comb begin
        imem_req    = issue;
        imem_addr   = fetch_pc_q;
        queue_count = count_q;
        inst_valid  = (count_q != '0);
        inst        = inst_valid ? mem_inst_q[rd_ptr_q] : 32'h0;
        inst_pc     = inst_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, RESET_PC = 0
    logic          nreset, imem_req, inst_valid, inst_ready, redirect_valid;
    logic [31:0]   imem_addr, imem_rdata, inst, inst_pc, redirect_pc;
    logic [CW-1:0] queue_count;

    // Wrap instance, RESET_PC = FFFF_FFF8
    logic          w_nreset, w_imem_req, w_inst_valid, w_inst_ready, w_redirect_valid;
    logic [31:0]   w_imem_addr, w_imem_rdata, w_inst, w_inst_pc, w_redirect_pc;
    logic [CW-1:0] w_queue_count;

    int          nvec = 0;
    int          nerr = 0;
    int          pops = 0;
    logic [31:0] exp_pc;

    fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .nreset(nreset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .queue_count(queue_count)
    );

    fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .nreset(w_nreset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
        .inst_ready(w_inst_ready), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .queue_count(w_queue_count)
    );

    // Code memory contents: 0x00 -> AAAA0001, 0x04 -> AAAA0002, ... (unique per word)
    function automatic logic [31:0] code(input logic [31:0] a);
        return 32'hAAAA_0001 + (a >> 2);
    endfunction

    // Synchronous code memories; garbage when no request so a bogus push is visible
    always @(posedge clk) imem_rdata   <= imem_req   ? code(imem_addr)   : 32'hDEAD_BEEF;
    always @(posedge clk) w_imem_rdata <= w_imem_req ? code(w_imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive the main instance's inputs for this cycle, then let combinational outputs settle
    task automatic set_in(input logic rdy, input logic rv, input logic [31:0] rpc);
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #2;
    endtask

    // Reference model: the core must see the instruction stream in PC order starting at the
    // last reset/redirect target, with each word's code-memory contents and nothing else.
    task automatic tick();
        if (nreset) begin
            chk("valid_vs_count", 32'(inst_valid), 32'(queue_count != '0));
            chk("no_overflow", 32'(queue_count > CW'(DEPTH)), 32'd0);
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (inst_valid && inst_ready) begin
                chk("pop_pc", inst_pc, exp_pc);
                chk("pop_inst", inst, code(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        exp_pc = 32'h0;
    endtask

    initial begin
        logic        rdy, rv;
        logic [31:0] rpc;
        nreset = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        w_nreset = 1'b0; w_inst_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0;
        exp_pc = 32'h0;

        // Reset state
        #1;
        chk("rst_req",   32'(imem_req),    32'd0);
        chk("rst_valid", 32'(inst_valid),  32'd0);
        chk("rst_inst",  inst,             32'd0);
        chk("rst_pc",    inst_pc,          32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);

        // PC wrap on the second instance (main instance held in reset)
        @(posedge clk); #1;
        w_nreset = 1'b1; #2;
        chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFF8);
        chk("wrap_req0",  32'(w_imem_req), 32'd1);
        @(posedge clk); #3;
        chk("wrap_addr1", w_imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #3;
        chk("wrap_addr2", w_imem_addr, 32'h0000_0000);
        chk("wrap_pc0",   w_inst_pc,   32'hFFFF_FFF8);
        chk("wrap_inst0", w_inst,      code(32'hFFFF_FFF8));
        @(posedge clk); #3;
        chk("wrap_pc1",   w_inst_pc,   32'hFFFF_FFFC);
        @(posedge clk); #3;
        chk("wrap_pc2",   w_inst_pc,   32'h0000_0000);
        chk("wrap_inst2", w_inst,      code(32'h0000_0000));
        @(posedge clk); #1;

        // Basic streaming from reset with inst_ready=1
        inst_ready = 1'b1;
        do_reset();
        set_in(1, 0, 0);
        chk("t1_req0", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_valid0", 32'(inst_valid), 32'd0);
        tick();
        set_in(1, 0, 0);
        chk("t1_addr1", imem_addr, 32'h4);
        chk("t1_valid1", 32'(inst_valid), 32'd0);
        tick();
        set_in(1, 0, 0);
        chk("t1_addr2", imem_addr, 32'h8);
        chk("t1_valid2", 32'(inst_valid), 32'd1);
        chk("t1_inst2", inst, 32'hAAAA_0001);
        chk("t1_pc2", inst_pc, 32'h0);
        tick();
        repeat (6) begin
            set_in(1, 0, 0);
            chk("t1_stream_valid", 32'(inst_valid), 32'd1);
            chk("t1_stream_req", 32'(imem_req), 32'd1);
            tick();
        end

        // Fill to DEPTH with inst_ready=0, then drain
        inst_ready = 1'b0;
        do_reset();
        repeat (8) begin set_in(0, 0, 0); tick(); end
        set_in(0, 0, 0);
        chk("t2_full_count", 32'(queue_count), 32'(DEPTH));
        chk("t2_full_req", 32'(imem_req), 32'd0);
        chk("t2_full_addr", imem_addr, 32'h10);
        repeat (12) begin set_in(1, 0, 0); tick(); end

        // Redirect with 3 queued and 1 in flight
        inst_ready = 1'b0;
        do_reset();
        repeat (4) begin set_in(0, 0, 0); tick(); end
        set_in(0, 1, 32'h0000_0043);
        chk("t3_pre_count", 32'(queue_count), 32'd3);
        chk("t3_redir_req", 32'(imem_req), 32'd0);
        tick();
        set_in(1, 0, 0);
        chk("t3_count0", 32'(queue_count), 32'd0);
        chk("t3_valid0", 32'(inst_valid), 32'd0);
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", imem_addr, 32'h40);
        tick();
        set_in(1, 0, 0);
        chk("t3_valid1", 32'(inst_valid), 32'd0);
        tick();
        set_in(1, 0, 0);
        chk("t3_valid2", 32'(inst_valid), 32'd1);
        chk("t3_first_pc", inst_pc, 32'h40);
        tick();
        repeat (4) begin set_in(1, 0, 0); tick(); end

        // Redirect during a pop, then back-to-back redirects (0x20 then 0x80)
        set_in(1, 1, 32'h20);
        chk("t4_pop_valid", 32'(inst_valid), 32'd1);
        chk("t4_req_a", 32'(imem_req), 32'd0);
        tick();
        set_in(1, 1, 32'h80);
        chk("t4_valid_b", 32'(inst_valid), 32'd0);
        chk("t4_req_b", 32'(imem_req), 32'd0);
        tick();
        set_in(1, 0, 0);
        chk("t4_req_c", 32'(imem_req), 32'd1);
        chk("t4_addr_c", imem_addr, 32'h80);
        chk("t4_valid_c", 32'(inst_valid), 32'd0);
        tick();
        set_in(1, 0, 0);
        chk("t4_addr_d", imem_addr, 32'h84);
        chk("t4_valid_d", 32'(inst_valid), 32'd0);
        tick();
        set_in(1, 0, 0);
        chk("t4_first_pc", inst_pc, 32'h80);
        tick();
        repeat (4) begin set_in(1, 0, 0); tick(); end

        // Asynchronous reset mid-stream with two entries queued
        inst_ready = 1'b0;
        do_reset();
        repeat (3) begin set_in(0, 0, 0); tick(); end
        set_in(0, 0, 0);
        chk("t6_pre_count", 32'(queue_count), 32'd2);
        nreset = 1'b0;
        #1;
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_valid", 32'(inst_valid), 32'd0);
        chk("t6_inst", inst, 32'd0);
        chk("t6_pc", inst_pc, 32'd0);
        chk("t6_count", 32'(queue_count), 32'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        exp_pc = 32'h0;
        set_in(1, 0, 0);
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", imem_addr, 32'h0);
        tick();
        set_in(1, 0, 0); tick();
        set_in(1, 0, 0);
        chk("t6_first_pc", inst_pc, 32'h0);
        chk("t6_first_inst", inst, 32'hAAAA_0001);
        tick();

        // Randomized backpressure and redirects against the stream model
        pops = 0;
        repeat (400) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            set_in(rdy, rv, rpc);
            tick();
        end
        chk("rand_progress", 32'(pops >= 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
